// File: rtl/aes_wb_ctrl_if.sv
// Wishbone slave bus bundle between the management SoC and the AES controller.
interface aes_wb_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/aes_wb_ctrl.sv
// Wishbone register front-end and sequencing FSM for an iterative AES-128 core.
// Holds key/block/result registers and raises a maskable completion interrupt.
module aes_wb_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  aes_wb_ctrl_if.slave   wbs,
  output logic           aes_init,
  output logic           aes_next,
  output logic           aes_encdec,
  output logic [127:0]   aes_key,
  output logic [127:0]   aes_block,
  input  logic           aes_ready,
  input  logic [127:0]   aes_result,
  output logic           irq
);

  localparam int unsigned TMO_W = 10;
  localparam int unsigned IDX_W = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_INIT, S_KEY_WAIT, S_BLK_START, S_BLK_WAIT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               ack_q, ack_d;
  logic               stall_q, stall_d;
  logic [31:0]        dat_q, dat_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       din_q, din_d;
  logic [127:0]       dout_q, dout_d;
  logic               encdec_q, encdec_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               kv_q, kv_d;
  logic               init_q, init_d;
  logic               next_q, next_d;
  logic               irq_q, irq_d;

  logic               sel_c, acc_c, wr_c, rd_c, idle_c, cfg_wr_c, start_c, busy_c;
  logic [IDX_W-1:0]   widx_c;
  logic [31:0]        rdata_c;
  logic               unused_adr_lsb;

  assign unused_adr_lsb = ^wbs.wbs_adr_i[1:0];

  assign sel_c    = wbs.wbs_stb_i && wbs.wbs_cyc_i && (wbs.wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign widx_c   = wbs.wbs_adr_i[7:2];
  assign acc_c    = sel_c && !ack_q && !stall_q;
  assign wr_c     = acc_c && wbs.wbs_we_i;
  assign rd_c     = acc_c && !wbs.wbs_we_i;
  assign idle_c   = (state_q == S_IDLE);
  assign busy_c   = !idle_c;
  assign cfg_wr_c = wr_c && idle_c;
  assign start_c  = cfg_wr_c && (widx_c == IDX_W'(0)) && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0];

  // Read-data mux; unmapped offsets read as zero.
  always_comb begin
    rdata_c = '0;
    case (widx_c)
      6'h00: rdata_c = {29'd0, irq_en_q, encdec_q, 1'b0};
      6'h01: rdata_c = {28'd0, err_q, kv_q, done_q, busy_c};
      6'h04: rdata_c = key_q[31:0];
      6'h05: rdata_c = key_q[63:32];
      6'h06: rdata_c = key_q[95:64];
      6'h07: rdata_c = key_q[127:96];
      6'h08: rdata_c = din_q[31:0];
      6'h09: rdata_c = din_q[63:32];
      6'h0a: rdata_c = din_q[95:64];
      6'h0b: rdata_c = din_q[127:96];
      6'h0c: rdata_c = dout_q[31:0];
      6'h0d: rdata_c = dout_q[63:32];
      6'h0e: rdata_c = dout_q[95:64];
      6'h0f: rdata_c = dout_q[127:96];
      default: rdata_c = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    ack_d    = acc_c;
    stall_d  = sel_c && (ack_q || stall_q);
    dat_d    = rd_c ? rdata_c : 32'd0;
    key_d    = key_q;
    din_d    = din_q;
    dout_d   = dout_q;
    encdec_d = encdec_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;
    kv_d     = kv_q;
    init_d   = 1'b0;
    next_d   = 1'b0;

    // Register writes; KEY/DIN/CTRL are frozen while a sequence is running.
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (cfg_wr_c && widx_c == IDX_W'(4 + i) && wbs.wbs_sel_i[b]) begin
          key_d[i*32 + b*8 +: 8] = wbs.wbs_dat_i[b*8 +: 8];
        end
        if (cfg_wr_c && widx_c == IDX_W'(8 + i) && wbs.wbs_sel_i[b]) begin
          din_d[i*32 + b*8 +: 8] = wbs.wbs_dat_i[b*8 +: 8];
        end
      end
    end
    if (cfg_wr_c && widx_c >= IDX_W'(4) && widx_c <= IDX_W'(7)) begin
      kv_d = 1'b0;
    end
    if (cfg_wr_c && widx_c == IDX_W'(0) && wbs.wbs_sel_i[0]) begin
      encdec_d = wbs.wbs_dat_i[1];
      irq_en_d = wbs.wbs_dat_i[2];
    end
    if (wr_c && widx_c == IDX_W'(1) && wbs.wbs_sel_i[0]) begin
      if (wbs.wbs_dat_i[1]) done_d = 1'b0;
      if (wbs.wbs_dat_i[3]) err_d  = 1'b0;
    end

    // Ready is ignored during the pulse cycle: the core only drops it afterwards.
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = kv_q ? S_BLK_START : S_KEY_INIT;
        end
      end
      S_KEY_INIT: begin
        if (aes_ready) begin
          init_d  = 1'b1;
          state_d = S_KEY_WAIT;
        end
      end
      S_KEY_WAIT: begin
        if (aes_ready && !init_q) begin
          kv_d    = 1'b1;
          state_d = S_BLK_START;
        end
      end
      S_BLK_START: begin
        if (aes_ready) begin
          next_d  = 1'b1;
          state_d = S_BLK_WAIT;
        end
      end
      S_BLK_WAIT: begin
        if (aes_ready && !next_q) begin
          dout_d  = aes_result;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Per-state watchdog on the core handshake.
    if (state_q != S_IDLE && state_q != S_DONE && state_d == state_q) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
        err_d   = 1'b1;
        kv_d    = 1'b0;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    irq_d = irq_en_d && (done_d || err_d);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      ack_q    <= 1'b0;
      stall_q  <= 1'b0;
      dat_q    <= '0;
      key_q    <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      encdec_q <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      kv_q     <= 1'b0;
      init_q   <= 1'b0;
      next_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      ack_q    <= ack_d;
      stall_q  <= stall_d;
      dat_q    <= dat_d;
      key_q    <= key_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      encdec_q <= encdec_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      kv_q     <= kv_d;
      init_q   <= init_d;
      next_q   <= next_d;
      irq_q    <= irq_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign aes_init      = init_q;
  assign aes_next      = next_q;
  assign aes_encdec    = encdec_q;
  assign aes_key       = key_q;
  assign aes_block     = din_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_aes_wb_ctrl.sv
// Directed bench for aes_wb_ctrl with a behavioural fixed-latency AES core model.
module tb_aes_wb_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RUN2_CT  = 128'ha5a4a7a6_a1a0a3a2_adacafae_a9a8abaa;
  localparam int           CORE_LAT = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         aes_init, aes_next, aes_encdec, irq;
  logic [127:0] aes_key, aes_block;
  logic         core_ready = 1'b1;
  logic [127:0] core_result = '0;
  logic         core_hold = 1'b0;
  logic         core_op_next = 1'b0;
  int           core_cnt = 0;
  int           n_init = 0;
  int           n_next = 0;
  int           total = 0;
  int           bad = 0;

  aes_wb_ctrl_if bus ();

  aes_wb_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs        (bus),
    .aes_init   (aes_init),
    .aes_next   (aes_next),
    .aes_encdec (aes_encdec),
    .aes_key    (aes_key),
    .aes_block  (aes_block),
    .aes_ready  (core_ready),
    .aes_result (core_result),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Core model: ready drops after a pulse, returns after CORE_LAT cycles.
  always @(posedge clk) begin
    if (aes_init || aes_next) begin
      core_ready   <= 1'b0;
      core_cnt     <= CORE_LAT;
      core_op_next <= aes_next;
    end else if (!core_ready && core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end else if (!core_ready && !core_hold) begin
      core_ready <= 1'b1;
      if (core_op_next)
        core_result <= (aes_key == FIPS_KEY && aes_block == FIPS_PT) ? FIPS_CT : (aes_key ^ aes_block);
    end
  end

  always @(posedge clk) begin
    if (aes_init) n_init <= n_init + 1;
    if (aes_next) n_next <= n_next + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] wd,
                         input logic [3:0] sel, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = {24'h300000, off};
    bus.wbs_dat_i = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.wbs_ack_o && n < 8);
    if (!bus.wbs_ack_o) chk("bus_ack_timeout", 128'(bus.wbs_ack_o), 128'd1);
    rd = bus.wbs_dat_o;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] wd);
    logic [31:0] d;
    wb_xfer(1'b1, off, wd, 4'hf, d);
  endtask

  task automatic wb_rd(input logic [7:0] off, output logic [31:0] rd);
    wb_xfer(1'b0, off, 32'd0, 4'hf, rd);
  endtask

  task automatic rd_dout(output logic [127:0] v);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      wb_rd(8'(8'h30 + 4 * i), w);
      v[i*32 +: 32] = w;
    end
  endtask

  task automatic wr_block(input logic [7:0] base, input logic [127:0] v);
    for (int i = 0; i < 4; i++) wb_wr(8'(base + 8'(4 * i)), v[i*32 +: 32]);
  endtask

  task automatic wait_irq(input int limit, output int cyc);
    cyc = 0;
    while (!irq && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!irq) chk("irq_wait_timeout", 128'(irq), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  d;
    logic [127:0] v;
    int           c, i0, n0;

    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_outs", {aes_init, aes_next, aes_encdec, irq, bus.wbs_ack_o}, 128'd0);
    chk("rst_key_blk", aes_key | aes_block, 128'd0);
    for (int a = 0; a < 16; a++) begin
      wb_rd(8'(4 * a), d);
      chk($sformatf("rst_rd_%02h", 4 * a), 128'(d), 128'd0);
    end

    // Ack timing: one cycle after selection, single cycle while stb is held.
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3000_0004;
    chk("ack_lat0", 128'(bus.wbs_ack_o), 128'd0);
    @(posedge clk); #1;
    chk("ack_lat1", 128'(bus.wbs_ack_o), 128'd1);
    @(posedge clk); #1;
    chk("ack_single", 128'(bus.wbs_ack_o), 128'd0);
    @(posedge clk); #1;
    chk("ack_no_b2b", 128'(bus.wbs_ack_o), 128'd0);
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;

    // Run 1: key not valid, full init + next.
    wr_block(8'h10, FIPS_KEY);
    wr_block(8'h20, FIPS_PT);
    chk("key_out", aes_key, FIPS_KEY);
    chk("blk_out", aes_block, FIPS_PT);
    i0 = n_init; n0 = n_next;
    wb_wr(8'h00, 32'h5);
    wait_irq(300, c);
    chk("r1_init_cnt", 128'(n_init - i0), 128'd1);
    chk("r1_next_cnt", 128'(n_next - n0), 128'd1);
    rd_dout(v);
    chk("r1_dout", v, FIPS_CT);
    wb_rd(8'h04, d);
    chk("r1_status", 128'(d), 128'h6);
    wb_rd(8'h00, d);
    chk("r1_ctrl", 128'(d), 128'h4);
    chk("r1_irq", 128'(irq), 128'd1);
    wb_wr(8'h04, 32'h2);
    @(posedge clk); #1;
    chk("r1_irq_clr", 128'(irq), 128'd0);
    wb_rd(8'h04, d);
    chk("r1_status_clr", 128'(d), 128'h4);

    // Run 2: key valid, only next pulse.
    wr_block(8'h20, {4{32'ha5a5a5a5}});
    i0 = n_init; n0 = n_next;
    wb_wr(8'h00, 32'h5);
    wait_irq(300, c);
    chk("r2_init_cnt", 128'(n_init - i0), 128'd0);
    chk("r2_next_cnt", 128'(n_next - n0), 128'd1);
    rd_dout(v);
    chk("r2_dout", v, RUN2_CT);
    wb_wr(8'h04, 32'h2);

    // Run 3: KEY write and START during BUSY are ignored.
    i0 = n_init; n0 = n_next;
    wb_wr(8'h00, 32'h5);
    wb_rd(8'h04, d);
    chk("r3_busy", 128'(d[0]), 128'd1);
    wb_wr(8'h10, 32'hffffffff);
    wb_wr(8'h00, 32'h5);
    wait_irq(300, c);
    repeat (30) @(posedge clk);
    #1;
    chk("r3_init_cnt", 128'(n_init - i0), 128'd0);
    chk("r3_next_cnt", 128'(n_next - n0), 128'd1);
    rd_dout(v);
    chk("r3_dout", v, RUN2_CT);
    wb_rd(8'h10, d);
    chk("r3_key0", 128'(d), 128'h0c0d0e0f);
    wb_rd(8'h04, d);
    chk("r3_status", 128'(d), 128'h6);
    wb_wr(8'h04, 32'h2);

    // Timeout: core never returns ready after next.
    core_hold = 1'b1;
    n0 = n_next;
    wb_wr(8'h00, 32'h5);
    wait_irq(1500, c);
    chk("tmo_cycles_in_window", 128'(c >= 1020 && c <= 1030), 128'd1);
    chk("tmo_next_cnt", 128'(n_next - n0), 128'd1);
    wb_rd(8'h04, d);
    chk("tmo_status", 128'(d), 128'h8);
    rd_dout(v);
    chk("tmo_dout_kept", v, RUN2_CT);
    core_hold = 1'b0;
    repeat (3) @(posedge clk);
    wb_wr(8'h04, 32'h8);
    @(posedge clk); #1;
    chk("tmo_irq_clr", 128'(irq), 128'd0);

    // Reset while in BLK_WAIT (key invalid so init runs first).
    n0 = n_next;
    wb_wr(8'h00, 32'h5);
    c = 0;
    while (n_next == n0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("rst_seq_reached_next", 128'(n_next - n0), 128'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_outs", {aes_init, aes_next, aes_encdec, irq, bus.wbs_ack_o}, 128'd0);
    chk("midrst_key_blk", aes_key | aes_block | 128'(bus.wbs_dat_o), 128'd0);
    i0 = n_init; n0 = n_next;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_pulses", 128'((n_init - i0) + (n_next - n0)), 128'd0);
    wb_rd(8'h04, d);
    chk("midrst_status", 128'(d), 128'd0);
    wr_block(8'h10, FIPS_KEY);
    wr_block(8'h20, FIPS_PT);
    i0 = n_init; n0 = n_next;
    wb_wr(8'h00, 32'h5);
    wait_irq(300, c);
    chk("post_rst_init", 128'(n_init - i0), 128'd1);
    rd_dout(v);
    chk("post_rst_dout", v, FIPS_CT);
    wb_wr(8'h04, 32'h2);

    // Byte enables on KEY and unmapped offsets.
    wb_wr(8'h10, 32'h11223344);
    wb_xfer(1'b1, 8'h10, 32'haabbccdd, 4'b0101, d);
    wb_rd(8'h10, d);
    chk("sel_key0", 128'(d), 128'h11bb33dd);
    wb_rd(8'h04, d);
    chk("kv_cleared_by_key_wr", 128'(d[2]), 128'd0);
    wb_wr(8'h40, 32'hdeadbeef);
    wb_rd(8'h40, d);
    chk("unmapped_40", 128'(d), 128'd0);
    wb_rd(8'hfc, d);
    chk("unmapped_fc", 128'(d), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
